imem_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the synchronous instruction ROM. The ROM registers its word address on clk and returns inst one cycle later.
- Owns the fetch PC and drives the ROM word address.
- Pairs each returned instruction with its PC and hands it to decode over a valid/ready handshake.
- Handles decode back-pressure and branch/jump redirects from execute.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/imem_fetch_perf.sv | 32 +++
 rtl/imem_fetch.sv | 90 +++++++++
 tb/tb_imem_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch FSM state encoding and the default boot address.
package cpu_pkg;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned IMEM_AW = 30;

  localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] INST_NOP         = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/imem_fetch_perf.sv
// Fetch performance counters (transfers and stall cycles); compiled only when
// IMEM_FETCH_PERF_EN is defined.
`ifdef IMEM_FETCH_PERF_EN
module imem_fetch_perf
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_fetch,
  input  logic            inc_stall,
  output logic [PC_W-1:0] fetch_count,
  output logic [PC_W-1:0] stall_count
);

  logic [PC_W-1:0] r_fetch_count;
  logic [PC_W-1:0] r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (inc_fetch) r_fetch_count <= r_fetch_count + 32'd1;
      if (inc_stall) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;

endmodule
`endif

// File: rtl/imem_fetch.sv
// Instruction-fetch stage feeding a synchronous ROM and handing PC/inst pairs to
// decode over valid/ready. Optional counters via IMEM_FETCH_PERF_EN.
module imem_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_inst,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [PC_W-1:0]    if_pc,
  output logic [INST_W-1:0]  if_inst,
  output logic [PC_W-1:0]    fetch_count,
  output logic [PC_W-1:0]    stall_count
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_resp_pc;
  logic [PC_W-1:0] w_resp_pc_nxt;
  logic [PC_W-1:0] w_redirect_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_if_valid;

  assign w_redirect_pc = redirect_pc & ~32'd3;
  assign w_pc_inc      = r_resp_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BOOT;
      r_resp_pc <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_resp_pc <= w_resp_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = RUN;
    w_resp_pc_nxt = r_resp_pc;
    w_if_valid    = 1'b0;
    case (r_state)
      BOOT: begin
        w_resp_pc_nxt = redirect_valid ? w_redirect_pc : RESET_PC;
      end
      RUN: begin
        w_if_valid = ~redirect_valid;
        if (redirect_valid)  w_resp_pc_nxt = w_redirect_pc;
        else if (!if_ready)  w_resp_pc_nxt = r_resp_pc;
        else                 w_resp_pc_nxt = w_pc_inc;
      end
      default: begin
        w_state_nxt   = BOOT;
        w_resp_pc_nxt = RESET_PC;
      end
    endcase
  end

  // The ROM address is always the PC the next response will belong to.
  assign imem_addr = rst ? RESET_PC[PC_W-1:2] : w_resp_pc_nxt[PC_W-1:2];
  assign if_valid  = w_if_valid;
  assign if_pc     = r_resp_pc;
  assign if_inst   = imem_inst;

`ifdef IMEM_FETCH_PERF_EN
  logic w_xfer;
  logic w_stall;

  assign w_xfer  = w_if_valid & if_ready;
  assign w_stall = w_if_valid & ~if_ready;

  imem_fetch_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .inc_fetch   (w_xfer),
    .inc_stall   (w_stall),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch with a registered-address ROM model; a second
// instance checks a non-default RESET_PC.
module tb_imem_fetch;

`ifdef IMEM_FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic [29:0] imem_addr;
  logic [31:0] imem_inst;
  logic        if_valid;
  logic [31:0] if_pc, if_inst, fetch_count, stall_count;

  logic [29:0] u2_imem_addr;
  logic [31:0] u2_imem_inst;
  logic        u2_if_valid;
  logic [31:0] u2_if_pc, u2_if_inst, u2_fetch_count, u2_stall_count;

  logic [31:0] rom [0:255];

  int checks = 0;
  int errors = 0;
  int exp_fetch = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  imem_fetch dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  imem_fetch #(.RESET_PC(32'h0000_0100)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(u2_imem_addr), .imem_inst(u2_imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(u2_if_valid), .if_ready(if_ready), .if_pc(u2_if_pc), .if_inst(u2_if_inst),
    .fetch_count(u2_fetch_count), .stall_count(u2_stall_count)
  );

  always @(posedge clk) begin
    imem_inst    <= rom[imem_addr[7:0]];
    u2_imem_inst <= rom[u2_imem_addr[7:0]];
  end

  // Advance one cycle, noting what the cycle just ended should have counted.
  task automatic adv(input bit xfer, input bit stall);
    if (xfer)  exp_fetch++;
    if (stall) exp_stall++;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    checks++;
    if (imem_addr !== 30'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++;
    if (u2_imem_addr !== 30'h40) begin errors++; $display("FAIL rst_addr2 got %h exp 40", u2_imem_addr); end
    checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", fetch_count, stall_count);
    end
    checks++;
    rst = 1'b0;
    #1;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", if_valid); end
    checks++;
    adv(1'b0, 1'b0);
  endtask

  task automatic test_boot;
    logic [31:0] exp_inst [0:2];
    exp_inst[0] = 32'h3c1d1000;
    exp_inst[1] = 32'h0c000003;
    exp_inst[2] = 32'h37bd4000;
    for (int i = 0; i < 3; i++) begin
      if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_inst !== exp_inst[i]) begin
        errors++;
        $display("FAIL boot_seq%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 i, if_valid, if_pc, if_inst, 32'(i * 4), exp_inst[i]);
      end
      checks++;
      adv(1'b1, 1'b0);
    end
    for (int pc = 12; pc <= 16; pc += 4) begin
      if (if_pc !== 32'(pc)) begin errors++; $display("FAIL boot_pc got %h exp %h", if_pc, 32'(pc)); end
      checks++;
      adv(1'b1, 1'b0);
    end
    if (fetch_count !== (PERF ? 32'd5 : 32'd0)) begin
      errors++; $display("FAIL boot_fetch_count got %0d exp %0d", fetch_count, PERF ? 5 : 0);
    end
    checks++;
  endtask

  task automatic test_stall;
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_inst !== 32'h3c028000 || imem_addr !== 30'h5) begin
        errors++;
        $display("FAIL stall%0d got v=%b pc=%h inst=%h addr=%h exp v=1 pc=14 inst=3c028000 addr=5",
                 i, if_valid, if_pc, if_inst, imem_addr);
      end
      checks++;
      adv(1'b0, 1'b1);
    end
    if_ready = 1'b1;
    #1;
    if (if_pc !== 32'h14 || stall_count !== (PERF ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL stall_end got pc=%h stalls=%0d exp pc=14 stalls=%0d", if_pc, stall_count, PERF ? 3 : 0);
    end
    checks++;
    adv(1'b1, 1'b0);
    if (if_pc !== 32'h18 || if_valid !== 1'b1) begin
      errors++; $display("FAIL stall_next got pc=%h v=%b exp pc=18 v=1", if_pc, if_valid);
    end
    checks++;
  endtask

  task automatic test_redirect;
    for (int pc = 'h18; pc < 'h74; pc += 4) begin
      if (if_pc !== 32'(pc)) begin errors++; $display("FAIL run_pc got %h exp %h", if_pc, 32'(pc)); end
      checks++;
      adv(1'b1, 1'b0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h16;
    #1;
    if (if_pc !== 32'h74 || if_valid !== 1'b0 || imem_addr !== 30'h5) begin
      errors++; $display("FAIL redir_squash got pc=%h v=%b addr=%h exp pc=74 v=0 addr=5", if_pc, if_valid, imem_addr);
    end
    checks++;
    adv(1'b0, 1'b0);
    redirect_valid = 1'b0;
    #1;
    if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_inst !== 32'h3c028000) begin
      errors++; $display("FAIL redir_target got v=%b pc=%h inst=%h exp v=1 pc=14 inst=3c028000", if_valid, if_pc, if_inst);
    end
    checks++;
  endtask

  task automatic test_redirect_stall;
    for (int i = 0; i < 5; i++) adv(1'b1, 1'b0);
    if (if_pc !== 32'h28) begin errors++; $display("FAIL rs_pc got %h exp 28", if_pc); end
    checks++;
    if_ready = 1'b0;
    adv(1'b0, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0c;
    #1;
    if (if_valid !== 1'b0 || imem_addr !== 30'h3) begin
      errors++; $display("FAIL rs_squash got v=%b addr=%h exp v=0 addr=3", if_valid, imem_addr);
    end
    checks++;
    adv(1'b0, 1'b0);
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    #1;
    if (if_valid !== 1'b1 || if_pc !== 32'h0c || if_inst !== 32'h0) begin
      errors++; $display("FAIL rs_target got v=%b pc=%h inst=%h exp v=1 pc=c inst=0", if_valid, if_pc, if_inst);
    end
    checks++;
    if (fetch_count !== (PERF ? 32'(exp_fetch) : 32'd0) || stall_count !== (PERF ? 32'(exp_stall) : 32'd0)) begin
      errors++; $display("FAIL rs_counts got %0d/%0d exp %0d/%0d", fetch_count, stall_count,
                         PERF ? exp_fetch : 0, PERF ? exp_stall : 0);
    end
    checks++;
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    if (imem_addr !== 30'h3FFF_FFFF) begin errors++; $display("FAIL wrap_addr0 got %h exp 3fffffff", imem_addr); end
    checks++;
    adv(1'b0, 1'b0);
    redirect_valid = 1'b0;
    #1;
    if (if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1 || if_inst !== 32'hA500_00FF || imem_addr !== 30'h0) begin
      errors++; $display("FAIL wrap_top got pc=%h v=%b inst=%h addr=%h exp pc=fffffffc v=1 inst=a50000ff addr=0",
                         if_pc, if_valid, if_inst, imem_addr);
    end
    checks++;
    adv(1'b1, 1'b0);
    if (if_pc !== 32'h0 || if_inst !== 32'h3c1d1000 || imem_addr !== 30'h1) begin
      errors++; $display("FAIL wrap_zero got pc=%h inst=%h addr=%h exp pc=0 inst=3c1d1000 addr=1", if_pc, if_inst, imem_addr);
    end
    checks++;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 16; i++) adv(1'b1, 1'b0);
    if (if_pc !== 32'h40 || if_valid !== 1'b1) begin
      errors++; $display("FAIL ar_pre got pc=%h v=%b exp pc=40 v=1", if_pc, if_valid);
    end
    checks++;
    #1;
    rst = 1'b1;
    #1;
    exp_fetch = 0;
    exp_stall = 0;
    if (if_valid !== 1'b0 || fetch_count !== 32'd0 || stall_count !== 32'd0 || imem_addr !== 30'h0) begin
      errors++; $display("FAIL ar_now got v=%b counts=%0d/%0d addr=%h exp v=0 counts=0/0 addr=0",
                         if_valid, fetch_count, stall_count, imem_addr);
    end
    checks++;
    if (u2_if_valid !== 1'b0 || u2_imem_addr !== 30'h40) begin
      errors++; $display("FAIL ar_now2 got v=%b addr=%h exp v=0 addr=40", u2_if_valid, u2_imem_addr);
    end
    checks++;
    adv(1'b0, 1'b0);
    adv(1'b0, 1'b0);
    rst = 1'b0;
    adv(1'b0, 1'b0);
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h3c1d1000) begin
      errors++; $display("FAIL ar_first got v=%b pc=%h inst=%h exp v=1 pc=0 inst=3c1d1000", if_valid, if_pc, if_inst);
    end
    checks++;
    if (u2_if_valid !== 1'b1 || u2_if_pc !== 32'h100 || u2_if_inst !== 32'hA500_0040) begin
      errors++; $display("FAIL ar_first2 got v=%b pc=%h inst=%h exp v=1 pc=100 inst=a5000040",
                         u2_if_valid, u2_if_pc, u2_if_inst);
    end
    checks++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | 32'(i);
    rom[0] = 32'h3c1d1000;
    rom[1] = 32'h0c000003;
    rom[2] = 32'h37bd4000;
    rom[3] = 32'h0000_0000;
    rom[5] = 32'h3c028000;

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    test_reset;
    test_boot;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_wrap;
    test_async_reset;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
